// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction-cache geometry, FSM encoding and line helpers.
package cpu_defs;

    localparam int ICACHE_IDX_W  = 6;
    localparam int ICACHE_LINE_W = 128;
    localparam int ICACHE_TAG_W  = 32 - 4 - ICACHE_IDX_W;

    typedef logic [ICACHE_TAG_W-1:0] icache_tag_t;

    // FSM encoding kept as plain constants for compatibility with older consumers.
    typedef logic [2:0] icache_state_t;
    localparam icache_state_t IDLE   = 3'd0;
    localparam icache_state_t LOOKUP = 3'd1;
    localparam icache_state_t MISS   = 3'd2;
    localparam icache_state_t WAIT   = 3'd3;
    localparam icache_state_t RESP   = 3'd4;

    function automatic logic [31:0] line_word(input logic [ICACHE_LINE_W-1:0] line,
                                              input logic [1:0] off);
        logic [31:0] w;
        case (off)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped icache: single write port, bulk invalidate, combinational hit.
module icache_tag_array
    import cpu_defs::*;
#(
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [27-IDX_W:0] rd_tag,
    output logic              hit,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [27-IDX_W:0] wr_tag,
    input  logic              wr_valid
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [27-IDX_W:0] tag_q [LINES];

    // Flush wins over a same-cycle refill, so that line comes up invalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped blocking instruction cache: 1-cycle hits, 16 B line refill, uncached single-word pass-through.
module icache_direct_mapped
    import cpu_defs::*;
#(
    parameter int IDX_W      = ICACHE_IDX_W,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         fetch_req,
    input  logic [31:0]  fetch_addr,
    input  logic         fetch_uncache,
    input  logic         fetch_flush,
    output logic         fetch_ready,
    output logic         fetch_valid,
    output logic [31:0]  fetch_rdata,
    output logic         icache_uncache,
    output logic         icache_req,
    output logic [31:0]  icache_addr,
    input  logic         icache_addr_ready,
    input  logic         icache_data_ready,
    input  logic [127:0] icache_rdata
);

    localparam int LINES  = 1 << IDX_W;
    localparam int LINE_W = 32 * LINE_WORDS;

    icache_state_t state_q;
    icache_state_t state_d;

    logic [31:0]       req_addr_p0;
    logic              req_unc_p0;
    logic              flush_seen_q;
    logic [31:0]       resp_word_p1;
    logic [LINE_W-1:0] data_q [LINES];

    logic [IDX_W-1:0]  req_idx;
    logic [27-IDX_W:0] req_tag;
    logic [1:0]        req_off;
    logic              tag_hit;
    logic              hit;
    logic              lookup_hit;
    logic              accept;
    logic              refill_done;
    logic              fill_en;

    assign req_idx = req_addr_p0[4+IDX_W-1:4];
    assign req_tag = req_addr_p0[31:4+IDX_W];
    assign req_off = req_addr_p0[3:2];

    icache_tag_array #(
        .IDX_W (IDX_W)
    ) u_tag_array (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (fetch_flush),
        .rd_idx   (req_idx),
        .rd_tag   (req_tag),
        .hit      (tag_hit),
        .wr_en    (fill_en),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_valid (!flush_seen_q)
    );

    assign hit         = tag_hit && !req_unc_p0;
    assign lookup_hit  = (state_q == LOOKUP) && hit;
    assign fetch_ready = resetn && ((state_q == IDLE) || lookup_hit || (state_q == RESP));
    assign accept      = fetch_req && fetch_ready;
    assign refill_done = (state_q == WAIT) && icache_data_ready;
    assign fill_en     = refill_done && !req_unc_p0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_req) state_d = LOOKUP;
            LOOKUP:  state_d = hit ? (fetch_req ? LOOKUP : IDLE) : MISS;
            MISS:    if (icache_addr_ready) state_d = WAIT;
            WAIT:    if (icache_data_ready) state_d = RESP;
            RESP:    state_d = fetch_req ? LOOKUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            flush_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (refill_done) begin
                flush_seen_q <= 1'b0;
            end else if (fetch_flush && ((state_q == MISS) || (state_q == WAIT))) begin
                flush_seen_q <= 1'b1;
            end
        end
    end

    // Request stage: the held address stays put until the next acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_p0 <= fetch_addr;
            req_unc_p0  <= fetch_uncache;
        end
    end

    // Refill stage: capture the requested word and, for cached fetches, the whole line.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            resp_word_p1 <= req_unc_p0 ? icache_rdata[127:96] : line_word(icache_rdata, req_off);
        end
        if (fill_en) begin
            data_q[req_idx] <= icache_rdata;
        end
    end

    always_comb begin
        fetch_rdata = 32'h0;
        if (lookup_hit) begin
            fetch_rdata = line_word(data_q[req_idx], req_off);
        end else if (state_q == RESP) begin
            fetch_rdata = resp_word_p1;
        end
    end

    assign fetch_valid    = lookup_hit || (state_q == RESP);
    assign icache_req     = (state_q == MISS);
    assign icache_uncache = (state_q == MISS) && req_unc_p0;
    assign icache_addr    = (state_q != MISS) ? 32'h0 :
                            (req_unc_p0 ? req_addr_p0 : {req_addr_p0[31:4], 4'b0000});

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped with an AXI-side responder and a fetch-word scoreboard.
module tb_icache_direct_mapped;

    logic         clk;
    logic         resetn;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         fetch_uncache;
    logic         fetch_flush;
    logic         fetch_ready;
    logic         fetch_valid;
    logic [31:0]  fetch_rdata;
    logic         icache_uncache;
    logic         icache_req;
    logic [31:0]  icache_addr;
    logic         icache_addr_ready;
    logic         icache_data_ready;
    logic [127:0] icache_rdata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] exp_q [$];
    int          vld_log [$];

    int          req_cnt = 0;
    logic [31:0] ax_addr = 32'h0;
    logic        ax_unc  = 1'b0;

    localparam int DATA_LAT = 2;

    icache_direct_mapped dut (
        .clk               (clk),
        .resetn            (resetn),
        .fetch_req         (fetch_req),
        .fetch_addr        (fetch_addr),
        .fetch_uncache     (fetch_uncache),
        .fetch_flush       (fetch_flush),
        .fetch_ready       (fetch_ready),
        .fetch_valid       (fetch_valid),
        .fetch_rdata       (fetch_rdata),
        .icache_uncache    (icache_uncache),
        .icache_req        (icache_req),
        .icache_addr       (icache_addr),
        .icache_addr_ready (icache_addr_ready),
        .icache_data_ready (icache_data_ready),
        .icache_rdata      (icache_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory image: every word distinct, one known instruction for the uncached case.
    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'hBFC0_0108) return 32'h2402_0001;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [127:0] mk_rdata(input logic [31:0] a, input logic unc);
        logic [31:0] b;
        b = {a[31:4], 4'b0000};
        if (unc) return {memw(a), 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        return {memw(b + 32'd12), memw(b + 32'd8), memw(b + 32'd4), memw(b)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // AXI responder: drives on the falling edge, address handshake then data after DATA_LAT.
    initial begin
        int  lat;
        bit  busy;
        lat = 0;
        busy = 0;
        icache_addr_ready = 1'b0;
        icache_data_ready = 1'b0;
        icache_rdata      = '0;
        forever begin
            @(negedge clk);
            icache_data_ready = 1'b0;
            if (!resetn) begin
                busy = 0;
                icache_addr_ready = 1'b0;
            end else if (icache_addr_ready) begin
                icache_addr_ready = 1'b0;
            end else if (busy) begin
                if (lat == 0) begin
                    icache_data_ready = 1'b1;
                    icache_rdata      = mk_rdata(ax_addr, ax_unc);
                    busy = 0;
                end else begin
                    lat--;
                end
            end else if (icache_req) begin
                icache_addr_ready = 1'b1;
                ax_addr = icache_addr;
                ax_unc  = icache_uncache;
                busy    = 1;
                lat     = DATA_LAT;
                req_cnt++;
            end
        end
    end

    // Scoreboard consumer.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (fetch_valid) begin
                vld_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("fetch_rdata", fetch_rdata, e);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic unc);
        int n;
        n = 0;
        fetch_req     = 1'b1;
        fetch_addr    = a;
        fetch_uncache = unc;
        while (!fetch_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("fetch_accept", {31'h0, fetch_ready}, 32'd1);
        if (fetch_ready) exp_q.push_back(memw(a));
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_handshake(input string tag);
        int n;
        n = 0;
        while (!icache_addr_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, {31'h0, icache_addr_ready}, 32'd1);
    endtask

    initial begin
        int c0;
        int n0;
        resetn        = 1'b0;
        fetch_req     = 1'b0;
        fetch_addr    = 32'h0;
        fetch_uncache = 1'b0;
        fetch_flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'd0);
        chk("rst_fetch_valid", {31'h0, fetch_valid}, 32'd0);
        chk("rst_icache_req", {31'h0, icache_req}, 32'd0);
        chk("rst_icache_addr", icache_addr, 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", {31'h0, fetch_ready}, 32'd1);

        // Cold miss
        c0 = req_cnt;
        fetch(32'hBFC0_0004, 1'b0);
        drain("cold_drain");
        chk("cold_reqs", 32'(req_cnt - c0), 32'd1);
        chk("cold_axaddr", ax_addr, 32'hBFC0_0000);
        chk("cold_axunc", {31'h0, ax_unc}, 32'd0);

        // Back-to-back hits
        c0 = req_cnt;
        n0 = vld_log.size();
        fetch(32'hBFC0_0000, 1'b0);
        fetch(32'hBFC0_0008, 1'b0);
        fetch(32'hBFC0_000C, 1'b0);
        drain("hit_drain");
        chk("hit_reqs", 32'(req_cnt - c0), 32'd0);
        chk("hit_count", 32'(vld_log.size() - n0), 32'd3);
        if (vld_log.size() >= n0 + 3) begin
            chk("hit_gap1", 32'(vld_log[n0+1] - vld_log[n0]), 32'd1);
            chk("hit_gap2", 32'(vld_log[n0+2] - vld_log[n0+1]), 32'd1);
        end

        // Uncached pass-through, never allocated
        c0 = req_cnt;
        fetch(32'hBFC0_0108, 1'b1);
        drain("unc_drain");
        chk("unc_reqs", 32'(req_cnt - c0), 32'd1);
        chk("unc_axaddr", ax_addr, 32'hBFC0_0108);
        chk("unc_axunc", {31'h0, ax_unc}, 32'd1);
        c0 = req_cnt;
        fetch(32'hBFC0_0108, 1'b1);
        drain("unc2_drain");
        chk("unc_repeat_reqs", 32'(req_cnt - c0), 32'd1);

        // Conflict on index 0
        c0 = req_cnt;
        fetch(32'h0000_0000, 1'b0);
        drain("cf0_drain");
        fetch(32'h0000_0400, 1'b0);
        drain("cf1_drain");
        chk("cf_axaddr", ax_addr, 32'h0000_0400);
        fetch(32'h0000_0000, 1'b0);
        drain("cf2_drain");
        chk("cf_reqs", 32'(req_cnt - c0), 32'd3);

        // Flush while the refill is outstanding
        c0 = req_cnt;
        fetch(32'h0000_0100, 1'b0);
        wait_handshake("fl_handshake");
        chk("fl_wait_req", {31'h0, icache_req}, 32'd0);
        fetch_flush = 1'b1;
        @(posedge clk);
        #1;
        fetch_flush = 1'b0;
        drain("fl_drain");
        fetch(32'h0000_0104, 1'b0);
        drain("fl2_drain");
        chk("fl_reqs", 32'(req_cnt - c0), 32'd2);

        // Reset in the middle of a refill
        fetch(32'h0000_0200, 1'b0);
        drain("rs0_drain");
        c0 = req_cnt;
        fetch(32'h0000_0200, 1'b0);
        drain("rs1_drain");
        chk("rs_hit_reqs", 32'(req_cnt - c0), 32'd0);
        fetch(32'h0000_0300, 1'b0);
        wait_handshake("rs_handshake");
        resetn = 1'b0;
        #1;
        chk("rs_fetch_valid", {31'h0, fetch_valid}, 32'd0);
        chk("rs_fetch_ready", {31'h0, fetch_ready}, 32'd0);
        chk("rs_fetch_rdata", fetch_rdata, 32'h0);
        chk("rs_icache_req", {31'h0, icache_req}, 32'd0);
        chk("rs_icache_unc", {31'h0, icache_uncache}, 32'd0);
        chk("rs_icache_addr", icache_addr, 32'h0);
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        c0 = req_cnt;
        fetch(32'h0000_0200, 1'b0);
        drain("rs2_drain");
        chk("rs_after_reqs", 32'(req_cnt - c0), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, blocking instruction cache sitting between the fetch stage and the CPU AXI interface's icache port.
- Serves cached hits with 1-cycle latency and refills 4-word (16 B) lines over the 128-bit line port.
- Passes uncached fetches through as single-word reads; uncached data is never allocated.

Parameters:
- IDX_W, 6, index width; number of lines = 2**IDX_W (64 lines = 1 KiB).
- LINE_WORDS, 4, words per line; fixed to 4 to match the 128-bit refill port and not meant to be overridden.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request valid
- fetch_addr  in  32  word-aligned PC
- fetch_uncache  in  1  request is uncached
- fetch_flush  in  1  invalidate all lines (1-cycle pulse)
- fetch_ready  out  1  request accepted this cycle when fetch_req=1
- fetch_valid  out  1  1-cycle pulse, fetch_rdata valid; there is no back-pressure
- fetch_rdata  out  32  instruction word
- icache_uncache  out  1  to AXI interface: single-beat read
- icache_req  out  1  line/word read request
- icache_addr  out  32  read address
- icache_addr_ready  in  1  address accepted when icache_req=1
- icache_data_ready  in  1  1-cycle pulse, icache_rdata valid
- icache_rdata  in  128  line data; word0 in [31:0] ... word3 in [127:96]; uncached word in [127:96]

Behaviour:
- Address split: tag = addr[31:4+IDX_W], index = addr[4+IDX_W-1:4], offset = addr[3:2].
- Storage: per-line valid bit, tag and 128-bit data, all in flops; combinational read indexed by the latched request.
- Reset (resetn=0, async):
  - state=IDLE, all valid bits=0.
  - fetch_valid=0, fetch_ready=0 while reset is asserted, icache_req=0, icache_uncache=0, icache_addr=0, fetch_rdata=0.
- States:
  - IDLE: no request held. fetch_ready=1.
  - LOOKUP: request latched last cycle. hit = valid & tag match & !uncache.
    - Hit: fetch_valid=1, fetch_rdata = line[32*offset +: 32], fetch_ready=1; next state LOOKUP if new req accepted, else IDLE.
    - Miss: fetch_ready=0, go MISS.
  - MISS: icache_req=1, held until icache_addr_ready.
    - Cached: icache_addr = {addr[31:4],4'b0}.
    - Uncached: icache_addr = addr and icache_uncache=1.
    - Address and uncache flag are stable while waiting. On icache_req & icache_addr_ready go WAIT.
  - WAIT: icache_req=0. On icache_data_ready:
    - Cached: write data/tag, set valid unless flush_seen; latch word = rdata[32*offset +: 32].
    - Uncached: latch word = rdata[127:96]; no array write.
    - Go RESP.
  - RESP: fetch_valid=1 with the latched word; fetch_ready=1; next state LOOKUP if req accepted, else IDLE.
- Latency:
  - Hit: 1 cycle after acceptance; back-to-back hits sustain 1 per cycle.
  - Miss: min 3 cycles + AXI latency.
- Flush:
  - In any state, clears all valid bits at the next edge.
  - In LOOKUP, the same-cycle hit result is still delivered.
  - If asserted in MISS or WAIT, sets flush_seen; the refilled line is written but left invalid, and the word is still returned. flush_seen is cleared on entering RESP.
- Simultaneous flush and fetch_req in IDLE: request accepted; its lookup sees the invalidated array, so it misses.
- A refill that replaces the line of the request currently held: not possible (blocking cache).
- Reset during MISS/WAIT: returns to IDLE; the outstanding AXI transaction is the system's concern (both blocks share reset).
- Request regs capture fetch_addr/fetch_uncache only when fetch_req & fetch_ready.

Decomposition:
- cpu_defs package gains:
  - icache_state_t (IDLE, LOOKUP, MISS, WAIT, RESP).
  - ICACHE_IDX_W, ICACHE_LINE_W=128.
  - Typedef icache_tag_t.
- One sub-module, icache_tag_array: valid+tag storage, async clear, bulk invalidate, single write port, combinational compare producing hit. The data array stays in the top level.

Test Plan:
- Cold miss: reset, fetch 0xBFC00004 cached. Required: icache_req with addr 0xBFC00000; after data_ready with rdata={W3,W2,W1,W0}, fetch_valid=1 and fetch_rdata=W1.
- Hit stream: fetch 0xBFC00000, 0x8, 0xC on consecutive cycles after that refill. Required: three consecutive fetch_valid pulses W0, W2, W3, and icache_req stays 0.
- Uncached: fetch 0xBFC00108 with uncache=1. Required: icache_addr=0xBFC00108, icache_uncache=1; rdata[127:96]=0x24020001 returned; a repeat fetch misses again.
- Conflict: fetch 0x00000000 then 0x00000400 (same index, IDX_W=6). Required: second is a miss, and refetching 0x0 misses again.
- Flush during WAIT: assert fetch_flush while refill of 0x100 is outstanding. Required: word still returned, and the next fetch of 0x104 misses.
- Reset mid-refill: drop resetn in WAIT. Required: all outputs 0 immediately; after release, the previously hit address misses.
